// File: rtl/alu_result_stage.sv
// Result stage behind the 16-bit ALU: holds the architectural flags register,
// returns CF to the ALU carry input and queues results toward writeback.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      F,
    input  logic [15:0]     Result,
    input  logic [5:0]      Status,
    input  logic [TAGW-1:0] Tag,
    output logic            Cin,
    output logic [5:0]      Flags,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_result,
    output logic [TAGW-1:0] out_tag,
    output logic            illegal_op
);

    logic [15:0]     r_data [DEPTH];
    logic [TAGW-1:0] r_tag  [DEPTH];
    logic            r_wptr;
    logic            r_rptr;
    logic [1:0]      r_count;
    logic [5:0]      r_flags;
    logic            r_illegal;

    logic            w_push;
    logic            w_pop;
    logic [5:0]      w_flags_next;
    logic            w_illegal;

    // in_ready comes only from the registered count, so a full queue never
    // accepts even when the head is popped in the same cycle.
    assign in_ready   = (r_count < 2'd2);
    assign out_valid  = (r_count != 2'd0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign out_result = out_valid ? r_data[r_rptr] : 16'h0000;
    assign out_tag    = out_valid ? r_tag[r_rptr]  : '0;
    assign Flags      = r_flags;
    assign Cin        = r_flags[5];
    assign illegal_op = r_illegal;

    // Flag bit order {CF,ZF,NF,VF,PF,AF}
    always_comb begin
        w_flags_next = r_flags;
        w_illegal    = 1'b0;
        casez (F)
            5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111:
                w_flags_next = Status;
            5'b010??:
                w_flags_next = {1'b0, Status[4], Status[3], 1'b0, Status[1], r_flags[0]};
            5'b10???:
                w_flags_next = {Status[5], Status[4], Status[3], r_flags[2], Status[1], r_flags[0]};
            default:
                w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
            r_flags   <= 6'b000000;
            r_illegal <= 1'b0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= Result;
                r_tag[r_wptr]  <= Tag;
                r_wptr         <= ~r_wptr;
                r_flags        <= w_flags_next;
                if (w_illegal) begin
                    r_illegal <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed literal checks plus randomized traffic
// compared every cycle against a queue-and-mask reference model.
module tb_alu_result_stage;

    localparam int TAGW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      F = 5'd0;
    logic [15:0]     Result = 16'h0;
    logic [5:0]      Status = 6'h0;
    logic [TAGW-1:0] Tag = '0;
    logic            Cin;
    logic [5:0]      Flags;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [15:0]     out_result;
    logic [TAGW-1:0] out_tag;
    logic            illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_stage #(.DEPTH(2), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .F(F), .Result(Result), .Status(Status), .Tag(Tag), .Cin(Cin),
        .Flags(Flags), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0]     res;
        logic [TAGW-1:0] tag;
    } ent_t;

    ent_t       m_q[$];
    logic [5:0] m_flags = 6'h0;
    logic       m_illegal = 1'b0;
    bit         m_init = 1'b0;

    // 1 arithmetic, 2 logic, 3 shift/rotate, 0 undefined
    function automatic int op_class(input logic [4:0] f);
        if (f inside {5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7}) return 1;
        if (f >= 5'd8 && f <= 5'd11) return 2;
        if (f >= 5'd16 && f <= 5'd23) return 3;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_flags   = 6'h0;
            m_illegal = 1'b0;
            m_init    = 1'b1;
        end else if (m_init) begin
            bit acc;
            logic [5:0] load, clr;
            acc = in_valid && (m_q.size() < 2);
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (acc) begin
                ent_t e;
                e.res = Result;
                e.tag = Tag;
                m_q.push_back(e);
                case (op_class(F))
                    1: begin load = 6'b111111; clr = 6'b000000; end
                    2: begin load = 6'b011010; clr = 6'b100100; end
                    3: begin load = 6'b111010; clr = 6'b000000; end
                    default: begin load = 6'b000000; clr = 6'b000000; m_illegal = 1'b1; end
                endcase
                m_flags = (m_flags & ~load & ~clr) | (Status & load);
            end
        end
    end

    always @(negedge clk) begin
        if (m_init && !rst) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < 2});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
            check("flags", {26'd0, Flags}, {26'd0, m_flags});
            check("cin", {31'd0, Cin}, {31'd0, m_flags[5]});
            check("illegal_op", {31'd0, illegal_op}, {31'd0, m_illegal});
            if (m_q.size() > 0) begin
                check("out_result", {16'd0, out_result}, {16'd0, m_q[0].res});
                check("out_tag", {29'd0, out_tag}, {29'd0, m_q[0].tag});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [4:0] f, input logic [5:0] s, input logic [15:0] r, input logic [2:0] t);
        in_valid = 1'b1;
        F        = f;
        Status   = s;
        Result   = r;
        Tag      = t;
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_flags", {26'd0, Flags}, 32'h0);
        check("rst_cin", {31'd0, Cin}, 32'h0);
        check("rst_in_ready", {31'd0, in_ready}, 32'h1);
        check("rst_out_valid", {31'd0, out_valid}, 32'h0);
        check("rst_out_result", {16'd0, out_result}, 32'h0);
        check("rst_illegal", {31'd0, illegal_op}, 32'h0);

        // ADD loads all flags
        drive(5'b00100, 6'b100011, 16'h0000, 3'd3);
        step();
        in_valid = 1'b0;
        check("add_flags", {26'd0, Flags}, 32'h23);
        check("add_cin", {31'd0, Cin}, 32'h1);
        check("add_out_valid", {31'd0, out_valid}, 32'h1);
        check("add_out_result", {16'd0, out_result}, 32'h0);
        check("add_out_tag", {29'd0, out_tag}, 32'h3);

        // AND: CF/VF cleared, AF kept
        drive(5'b01000, 6'b110110, 16'h8000, 3'd1);
        step();
        in_valid = 1'b0;
        check("and_flags", {26'd0, Flags}, 32'h13);
        check("full_in_ready", {31'd0, in_ready}, 32'h0);
        check("hold_out_result", {16'd0, out_result}, 32'h0);
        out_ready = 1'b1;
        step();
        check("pop1_result", {16'd0, out_result}, 32'h8000);
        step();
        check("drained", {31'd0, out_valid}, 32'h0);

        // SHR after Flags=000101 keeps VF and AF
        drive(5'b00100, 6'b000101, 16'h0011, 3'd2);
        step();
        check("pre_shr_flags", {26'd0, Flags}, 32'h05);
        drive(5'b10001, 6'b101010, 16'h0022, 3'd4);
        step();
        in_valid = 1'b0;
        check("shr_flags", {26'd0, Flags}, 32'h2F);
        step();
        step();
        out_ready = 1'b0;

        // Backpressure: 1,2 accepted, 3 held upstream
        drive(5'b00001, 6'b001001, 16'd1, 3'd1);
        step();
        drive(5'b00001, 6'b001001, 16'd2, 3'd2);
        step();
        check("bp_in_ready0", {31'd0, in_ready}, 32'h0);
        drive(5'b00001, 6'b001001, 16'd3, 3'd3);
        step();
        check("bp_still_full", {31'd0, in_ready}, 32'h0);
        check("bp_head1", {16'd0, out_result}, 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_head2", {16'd0, out_result}, 32'd2);
        check("bp_ready_back", {31'd0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        check("pushpop_head3", {16'd0, out_result}, 32'd3);
        check("pushpop_valid", {31'd0, out_valid}, 32'h1);
        check("pushpop_ready", {31'd0, in_ready}, 32'h1);
        step();
        check("bp_empty", {31'd0, out_valid}, 32'h0);
        check("bp_flags", {26'd0, Flags}, 32'h09);
        out_ready = 1'b0;

        // Undefined opcode still queues its result
        drive(5'b01100, 6'b111111, 16'h1234, 3'd5);
        step();
        in_valid = 1'b0;
        check("ill_flag", {31'd0, illegal_op}, 32'h1);
        check("ill_flags_kept", {26'd0, Flags}, 32'h09);
        check("ill_result", {16'd0, out_result}, 32'h1234);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_illegal", {31'd0, illegal_op}, 32'h0);
        check("rst2_flags", {26'd0, Flags}, 32'h0);
        check("rst2_out_valid", {31'd0, out_valid}, 32'h0);
        out_ready = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: F = 5'($urandom_range(1, 7));
                1: F = 5'($urandom_range(8, 11));
                2: F = 5'($urandom_range(16, 23));
                default: F = 5'($urandom);
            endcase
            Status = 6'($urandom);
            Result = 16'($urandom);
            Tag    = 3'($urandom);
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
